// File: rtl/tx_data_field_framer.sv
// 802.11a TX framer: serialises SIGNAL then scrambled SERVICE/PSDU/TAIL/PAD.
// Latency: first SIGNAL bit the cycle after iStart; a byte's first bit appears no earlier than the cycle after it is accepted.
// Backpressure: oReady while the hold register is empty; output stalls (oValid=0) only in PSDU when no byte is buffered.
module tx_data_field_framer #(
  parameter logic [6:0] SEED        = 7'b1011101,
  parameter bit         SCRAMBLE_EN = 1'b1,
  parameter int         LEN_W       = 12
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [3:0]       iRate,
  input  logic [LEN_W-1:0] iLength,
  input  logic [6:0]       iSeed,
  input  logic [7:0]       iData,
  input  logic             iValid,
  output logic             oReady,
  output logic             oData,
  output logic             oValid,
  output logic             oSignal,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr
);

  // Per-state bit counter must cover 8*LENGTH PSDU bits.
  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGNAL,
    ST_SERVICE,
    ST_PSDU,
    ST_TAIL,
    ST_PAD
  } state_t;

  // Data bits per OFDM symbol; 0 marks an illegal RATE code.
  function automatic logic [7:0] ndbps_of(input logic [3:0] rate);
    case (rate)
      4'b1101: ndbps_of = 8'd24;
      4'b1111: ndbps_of = 8'd36;
      4'b0101: ndbps_of = 8'd48;
      4'b0111: ndbps_of = 8'd72;
      4'b1001: ndbps_of = 8'd96;
      4'b1011: ndbps_of = 8'd144;
      4'b0001: ndbps_of = 8'd192;
      4'b0011: ndbps_of = 8'd216;
      default: ndbps_of = 8'd0;
    endcase
  endfunction

  // SIGNAL field packed so that bit 0 is transmitted first.
  function automatic logic [23:0] signal_field(input logic [3:0] rate, input logic [11:0] len);
    logic [23:0] f;
    f       = '0;
    f[0]    = rate[3];
    f[1]    = rate[2];
    f[2]    = rate[1];
    f[3]    = rate[0];
    f[16:5] = len;
    f[17]   = ^f[16:0];
    return f;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       ndbps_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [23:0]      sig_q;
  logic             err_q;
  logic [6:0]       scr_q;
  logic [7:0]       sym_q;
  logic [7:0]       hold_q;
  logic             hold_vld_q;
  logic [7:0]       sh_q;
  logic [3:0]       sh_cnt_q;
  logic [LEN_W-1:0] bytes_left_q;

  logic [11:0] len_field;
  logic        start_ok;
  logic        in_data;
  logic        psdu_stall;
  logic        emit;
  logic        psdu_bit;
  logic        raw_bit;
  logic        fb;
  logic        data_bit;
  logic        cnt_last;
  logic        sym_last;
  logic        frame_end;
  logic        accept;

  assign len_field  = 12'(iLength);
  assign start_ok   = iStart && (ndbps_of(iRate) != 8'd0) && (iLength != '0);
  assign in_data    = (state_q == ST_SERVICE) || (state_q == ST_PSDU) ||
                      (state_q == ST_TAIL) || (state_q == ST_PAD);
  assign psdu_stall = (state_q == ST_PSDU) && (sh_cnt_q == 4'd0) && !hold_vld_q;
  assign emit       = (state_q != ST_IDLE) && !psdu_stall;
  // With the shifter empty the hold byte is consumed directly, avoiding a bubble.
  assign psdu_bit   = (sh_cnt_q != 4'd0) ? sh_q[0] : hold_q[0];
  assign raw_bit    = (state_q == ST_PSDU) && psdu_bit;
  assign fb         = scr_q[6] ^ scr_q[3];
  assign data_bit   = SCRAMBLE_EN ? (raw_bit ^ fb) : raw_bit;
  assign cnt_last   = (cnt_q == '0);
  assign sym_last   = (sym_q == (ndbps_q - 8'd1));
  // Frame ends when the bit just emitted completes an OFDM symbol after TAIL.
  assign frame_end  = ((state_q == ST_TAIL) && cnt_last && sym_last) ||
                      ((state_q == ST_PAD) && sym_last);
  assign accept     = oReady && iValid;
  assign oBusy      = (state_q != ST_IDLE);
  assign oErr       = err_q;

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and serial outputs
  always_comb begin
    state_d = state_q;
    oValid  = 1'b0;
    oData   = 1'b0;
    oSignal = 1'b0;
    oReady  = 1'b0;
    oDone   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_SIGNAL;
      end
      ST_SIGNAL: begin
        oValid  = 1'b1;
        oSignal = 1'b1;
        oData   = sig_q[0];
        if (cnt_last) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        oValid = 1'b1;
        oData  = data_bit;
        oReady = !hold_vld_q && (bytes_left_q != '0);
        if (cnt_last) state_d = ST_PSDU;
      end
      ST_PSDU: begin
        oValid = !psdu_stall;
        oData  = !psdu_stall && data_bit;
        oReady = !hold_vld_q && (bytes_left_q != '0);
        if (!psdu_stall && cnt_last) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        oValid = 1'b1;
        oDone  = frame_end;
        if (cnt_last) state_d = sym_last ? ST_IDLE : ST_PAD;
      end
      ST_PAD: begin
        oValid = 1'b1;
        oData  = data_bit;
        oDone  = frame_end;
        if (sym_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame parameters, per-state bit counter, SIGNAL shifter and reject pulse
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ndbps_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && iStart && !start_ok;
      if (state_q == ST_IDLE) begin
        if (start_ok) begin
          ndbps_q <= ndbps_of(iRate);
          len_q   <= iLength;
          sig_q   <= signal_field(iRate, len_field);
          cnt_q   <= CNT_W'(23);
        end
      end else if (emit) begin
        if (state_q == ST_SIGNAL) sig_q <= {1'b0, sig_q[23:1]};
        if (cnt_last) begin
          case (state_q)
            ST_SIGNAL:  cnt_q <= CNT_W'(15);
            ST_SERVICE: cnt_q <= {len_q, 3'b000} - CNT_W'(1);
            ST_PSDU:    cnt_q <= CNT_W'(5);
            default:    cnt_q <= '0;
          endcase
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Scrambler and OFDM symbol counter; both hold still while PSDU is starved
  always_ff @(posedge iClk) begin
    if (iRst) begin
      scr_q <= '0;
      sym_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_ok) scr_q <= (iSeed == 7'd0) ? SEED : iSeed;
    end else if (state_q == ST_SIGNAL) begin
      sym_q <= '0;
    end else if (in_data && emit) begin
      scr_q <= {scr_q[5:0], fb};
      sym_q <= sym_last ? 8'd0 : (sym_q + 8'd1);
    end
  end

  // Byte path: hold register refilled from iData, shifter feeds the line LSB first
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      sh_q         <= '0;
      sh_cnt_q     <= '0;
      bytes_left_q <= '0;
    end else if (state_q == ST_IDLE) begin
      hold_vld_q <= 1'b0;
      sh_cnt_q   <= '0;
      if (start_ok) bytes_left_q <= iLength;
    end else begin
      if ((state_q == ST_PSDU) && emit) begin
        if (sh_cnt_q != 4'd0) begin
          sh_q     <= {1'b0, sh_q[7:1]};
          sh_cnt_q <= sh_cnt_q - 4'd1;
        end else begin
          sh_q       <= {1'b0, hold_q[7:1]};
          sh_cnt_q   <= 4'd7;
          hold_vld_q <= 1'b0;
        end
      end
      // oReady requires an empty hold, so this never collides with the drain above.
      if (accept) begin
        hold_q       <= iData;
        hold_vld_q   <= 1'b1;
        bytes_left_q <= bytes_left_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_data_field_framer.sv
// Scoreboard bench for tx_data_field_framer: stimulus pushes expected bits, a monitor pops on oValid.
// Two instances: scrambling enabled (default SEED) and scrambler bypassed.
// Directed frames with hand-computed SIGNAL/SERVICE/PSDU constants and frame lengths.
module tb_tx_data_field_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [3:0] rate = '0;
  logic [11:0] len = '0;
  logic [6:0] seed = '0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;

  logic a_ready, a_data, a_valid, a_sig, a_busy, a_done, a_err;
  logic b_ready, b_data, b_valid, b_sig, b_busy, b_done, b_err;

  always #5 clk = ~clk;

  tx_data_field_framer u_dut (
    .iClk(clk), .iRst(rst), .iStart(start_a), .iRate(rate), .iLength(len), .iSeed(seed),
    .iData(data), .iValid(valid), .oReady(a_ready), .oData(a_data), .oValid(a_valid),
    .oSignal(a_sig), .oBusy(a_busy), .oDone(a_done), .oErr(a_err)
  );

  tx_data_field_framer #(.SCRAMBLE_EN(1'b0)) u_raw (
    .iClk(clk), .iRst(rst), .iStart(start_b), .iRate(rate), .iLength(len), .iSeed(seed),
    .iData(data), .iValid(valid), .oReady(b_ready), .oData(b_data), .oValid(b_valid),
    .oSignal(b_sig), .oBusy(b_busy), .oDone(b_done), .oErr(b_err)
  );

  // Hand-derived constants (first transmitted bit is the MSB).
  localparam logic [23:0] SIG_A   = 24'b1011_0_001001100000_0_000000;
  localparam logic [15:0] SVC_7F  = 16'b00001110_11110010;
  localparam logic [15:0] SVC_DEF = 16'b01101100_00011001;
  localparam logic [7:0]  PSDU_A5 = 8'b10100101;

  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];   // {done, signal, data}
  logic       cap_q[$];
  logic       ref_q[$];
  int         vcount;
  int         gap_cnt;
  logic [7:0] mem[256];
  logic [2:0] mon_got, mon_want;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ndbps(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  // Reference frame: SIGNAL, then DATA bits indexed 0..N-1 over SERVICE/PSDU/TAIL/PAD.
  task automatic push_exp(input bit raw, input logic [3:0] r, input int l, input logic [6:0] sd);
    int nd, ndata, tail0;
    logic [23:0] sg;
    logic [11:0] lv;
    logic [6:0] s;
    logic in_b, fb, o;
    nd    = ndbps(r);
    lv    = 12'(l);
    sg    = '0;
    sg[0] = r[3];
    sg[1] = r[2];
    sg[2] = r[1];
    sg[3] = r[0];
    for (int i = 0; i < 12; i++) sg[5+i] = lv[i];
    sg[17] = ^sg[16:0];
    for (int i = 0; i < 24; i++) exp_q.push_back({1'b0, 1'b1, sg[i]});
    tail0 = 16 + 8 * l;
    ndata = ((22 + 8 * l + nd - 1) / nd) * nd;
    s = (sd == 7'd0) ? 7'b1011101 : sd;
    for (int k = 0; k < ndata; k++) begin
      in_b = (k >= 16 && k < tail0) ? mem[(k - 16) / 8][(k - 16) % 8] : 1'b0;
      fb = s[6] ^ s[3];
      o = raw ? in_b : (in_b ^ fb);
      if (k >= tail0 && k < tail0 + 6) o = 1'b0;
      s = {s[5:0], fb};
      exp_q.push_back({(k == ndata - 1), 1'b0, o});
    end
  endtask

  // Monitor: every valid output bit is checked against the scoreboard head.
  always @(negedge clk) begin
    if (a_valid || b_valid) begin
      mon_got = a_valid ? {a_done, a_sig, a_data} : {b_done, b_sig, b_data};
      cap_q.push_back(mon_got[0]);
      vcount++;
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        mon_want = exp_q.pop_front();
        check($sformatf("stream_bit[%0d]", vcount - 1), int'(mon_got), int'(mon_want));
      end
    end else if (a_busy || b_busy) begin
      gap_cnt++;
    end
  end

  // One frame: start, feed bytes (optional starvation / mid-frame iStart / mid-frame reset), wait for end.
  task automatic run_frame(input bit raw, input logic [3:0] r, input int l, input logic [6:0] sd,
                           input int stall_at, input int rst_at, input int restart_at,
                           input int exp_valid, input int exp_gap);
    int idx, stalled;
    bit done, rdy;
    push_exp(raw, r, l, sd);
    cap_q.delete();
    vcount = 0;
    gap_cnt = 0;
    @(posedge clk); #1;
    rate = r; len = 12'(l); seed = sd;
    if (raw) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    idx = 0; stalled = 0; done = 1'b0;
    for (int cyc = 1; cyc < 5000 && !done; cyc++) begin
      if (cyc == rst_at + 1) rst = 1'b0;
      rdy = raw ? b_ready : a_ready;
      // The hold+shift pair absorbs 6 withheld ready cycles, so 11 give a 5-cycle line gap.
      if (idx < l) begin
        if (rdy && idx == stall_at && stalled < 11) begin
          valid = 1'b0;
          stalled++;
        end else begin
          valid = 1'b1;
          data = mem[idx];
          if (rdy) idx++;
        end
      end else begin
        valid = 1'b0;
      end
      if (cyc == restart_at) begin
        rate = 4'b0000; len = 12'd5;
        if (raw) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == restart_at + 1) begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (cyc == rst_at) rst = 1'b1;
      @(negedge clk);
      if (cyc == restart_at + 1) check("busy_start_no_err", int'(raw ? b_err : a_err), 0);
      if (cyc == rst_at + 1) begin
        check("midframe_reset_outputs",
              int'({a_ready, a_data, a_valid, a_sig, a_busy, a_done, a_err}), 0);
        exp_q.delete();
        done = 1'b1;
      end else if (!(raw ? b_busy : a_busy)) begin
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    if (rst_at < 0) begin
      check("valid_cycles", vcount, exp_valid);
      check("valid_gap", gap_cnt, exp_gap);
      check("scoreboard_drained", exp_q.size(), 0);
    end
  endtask

  task automatic err_start(input logic [3:0] r, input int l);
    @(posedge clk); #1;
    rate = r; len = 12'(l); seed = 7'h7F; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    check("err_pulse", int'(a_err), 1);
    check("err_busy", int'(a_busy), 0);
    @(negedge clk);
    check("err_single", int'(a_err), 0);
    check("err_idle", int'({a_busy, a_valid}), 0);
  endtask

  task automatic field_check(input string name, input int first, input int n, input int exp);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(cap_q[first + i]);
    check(name, v, exp);
  endtask

  task automatic compare_ref(input string name);
    int diffs;
    diffs = 0;
    check({name, "_len"}, cap_q.size(), ref_q.size());
    for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
      if (cap_q[i] != ref_q[i]) diffs++;
    check(name, diffs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", int'({a_ready, a_data, a_valid, a_sig, a_busy, a_done, a_err,
                                 b_ready, b_data, b_valid, b_sig, b_busy, b_done, b_err}), 0);

    // Rate 1011, L=100, seed 7F: 24 + 144*6 = 888 cycles, 42 PAD bits.
    run_frame(1'b0, 4'b1011, 100, 7'h7F, -1, -1, -1, 888, 0);
    field_check("signal_field", 0, 24, int'(SIG_A));
    field_check("service_seed7f", 24, 16, int'(SVC_7F));
    ref_q = cap_q;

    // Rate 1101, L=2, iSeed=0 -> SEED; 38 bits pad to 48; stray iStart during TAIL ignored.
    run_frame(1'b0, 4'b1101, 2, 7'h00, -1, -1, 60, 72, 0);
    field_check("service_default_seed", 24, 16, int'(SVC_DEF));

    // Starved mid-PSDU: same stream, 5-cycle gap.
    run_frame(1'b0, 4'b1011, 100, 7'h7F, 50, -1, -1, 888, 5);
    compare_ref("stall_stream_match");

    err_start(4'b0000, 5);
    err_start(4'b1011, 0);

    // Reset mid-PSDU then a clean repeat of the first frame.
    run_frame(1'b0, 4'b1011, 100, 7'h7F, -1, 240, -1, 0, 0);
    run_frame(1'b0, 4'b1011, 100, 7'h7F, -1, -1, -1, 888, 0);
    compare_ref("post_reset_stream_match");

    // Bypass instance: L=1, A5 -> PSDU 10100101, TAIL 6 zeros, PAD 18 zeros.
    mem[0] = 8'hA5;
    run_frame(1'b1, 4'b1101, 1, 7'h7F, -1, -1, -1, 72, 0);
    field_check("raw_psdu", 40, 8, int'(PSDU_A5));
    field_check("raw_tail_pad", 48, 24, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
